// File: rtl/ternary_serial_alu.sv
// Trit-serial MIN/MAX/CONSENSUS/ANY over TRITS-trit words, LSB trit first; result accumulator can stand in for operand a.
// out_valid rises TRITS cycles after acceptance; in_ready only in IDLE, DONE holds the result until out_ready.
module ternary_serial_alu #(
  parameter int TRITS = 4,
  parameter int IDXW  = (TRITS > 1) ? $clog2(TRITS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*TRITS-1:0] in_a,
  input  logic [2*TRITS-1:0] in_b,
  input  logic [1:0]         in_op,
  input  logic               in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*TRITS-1:0] out_data,
  output logic               out_err
);

  localparam int         W      = 2 * TRITS;
  localparam logic [1:0] T_ZERO = 2'b01;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } opnd_t;

  state_t          state_q, state_d;
  opnd_t           opnd_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    res_q, res_d, acc_q;
  logic            err_q;

  logic [1:0] raw_a, raw_b, da, db, tr;
  logic       bad, last, accept, release_w;

  // Illegal code 11 is folded to '0' before the trit function sees it.
  function automatic logic [1:0] legal(input logic [1:0] t);
    return (t == 2'b11) ? T_ZERO : t;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = res_q;
  assign out_err   = err_q;
  assign accept    = in_valid & in_ready;
  assign release_w = out_valid & out_ready;
  assign last      = (idx_q == IDXW'(TRITS - 1));

  always_comb begin
    raw_a = T_ZERO;
    raw_b = T_ZERO;
    for (int i = 0; i < TRITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        raw_a = opnd_q.a[2*i +: 2];
        raw_b = opnd_q.b[2*i +: 2];
      end
    end
    bad = (raw_a == 2'b11) | (raw_b == 2'b11);
    da  = legal(raw_a);
    db  = legal(raw_b);
    // Codes are ordered '-'<'0'<'+', so plain unsigned compares give MIN/MAX.
    case (opnd_q.op)
      2'b00:   tr = (da < db) ? da : db;
      2'b01:   tr = (da > db) ? da : db;
      2'b10:   tr = (da == db) ? da : T_ZERO;
      default: tr = (da == db) ? da : (da == T_ZERO) ? db : (db == T_ZERO) ? da : T_ZERO;
    endcase
    res_d = res_q;
    for (int i = 0; i < TRITS; i++) begin
      if (idx_q == IDXW'(i)) res_d[2*i +: 2] = tr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (release_w) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q.a  <= {TRITS{T_ZERO}};
      opnd_q.b  <= {TRITS{T_ZERO}};
      opnd_q.op <= 2'b00;
      idx_q     <= '0;
      res_q     <= {TRITS{T_ZERO}};
      acc_q     <= {TRITS{T_ZERO}};
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        opnd_q.a  <= in_acc ? acc_q : in_a;
        opnd_q.b  <= in_b;
        opnd_q.op <= in_op;
        idx_q     <= '0;
        err_q     <= 1'b0;
      end
      if (state_q == RUN) begin
        res_q <= res_d;
        err_q <= err_q | bad;
        idx_q <= last ? '0 : idx_q + 1'b1;
      end
      if (release_w) acc_q <= res_q;
    end
  end

endmodule
